// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters with registered sync, blanking and pixel-fetch strobes.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int PIPE_LEAD = 2
) (
    input  logic        clk40,
    input  logic        rst,
    output logic [10:0] hPos,
    output logic [9:0]  vPos,
    output logic [9:0]  nextVPos,
    output logic        hsync,
    output logic        vsync,
    output logic        displayActive,
    output logic        hsyncStarting,
    output logic        nextFrameActive,
    output logic        lineStarting,
    output logic        lineEnding
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    output logic [7:0]  frameCount
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] LS_POS   = 11'(H_TOTAL - PIPE_LEAD);
    localparam logic [10:0] LE_POS   = 11'(H_VISIBLE - PIPE_LEAD);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // h_cnt_r/v_cnt_r hold the position to be presented at the next edge, so every
    // output is decoded from them one cycle early and lands aligned with hPos/vPos.
    logic [10:0] h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [10:0] h_nxt_s;
    logic [9:0]  v_nxt_s;
    logic [9:0]  nv_s;

    // Counter successors with explicit terminal-value wrap
    always_comb begin
        h_nxt_s = 11'd0;
        v_nxt_s = v_cnt_r;
        nv_s    = 10'd0;
        if (h_cnt_r == H_LAST) begin
            h_nxt_s = 11'd0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 11'd1;
            v_nxt_s = v_cnt_r;
        end
        if (v_cnt_r == V_LAST) begin
            nv_s = 10'd0;
        end else begin
            nv_s = v_cnt_r + 10'd1;
        end
    end

    // Position counters and all registered timing outputs
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            h_cnt_r         <= 11'd0;
            v_cnt_r         <= 10'd0;
            hPos            <= 11'd0;
            vPos            <= 10'd0;
            nextVPos        <= 10'd1;
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            displayActive   <= 1'b0;
            hsyncStarting   <= 1'b0;
            nextFrameActive <= 1'b1;
            lineStarting    <= 1'b0;
            lineEnding      <= 1'b0;
        end else begin
            h_cnt_r         <= h_nxt_s;
            v_cnt_r         <= v_nxt_s;
            hPos            <= h_cnt_r;
            vPos            <= v_cnt_r;
            nextVPos        <= nv_s;
            hsync           <= (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
            vsync           <= (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
            displayActive   <= (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
            hsyncStarting   <= (h_cnt_r == HS_START);
            nextFrameActive <= (nv_s < V_VIS);
            lineStarting    <= (h_cnt_r == LS_POS) && (nv_s < V_VIS);
            lineEnding      <= (h_cnt_r == LE_POS) && (v_cnt_r < V_VIS);
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    // Frame counter steps as the presented position wraps from the last pixel to 0/0
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            frameCount <= 8'd0;
        end else if ((hPos == H_LAST) && (vPos == V_LAST)) begin
            frameCount <= frameCount + 8'd1;
        end else begin
            frameCount <= frameCount;
        end
    end
`endif

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 40, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 128, hsync width in clocks.
REQ-004 SHALL have parameter H_BACK, default 88, horizontal back porch; H_TOTAL = sum of the four H parameters = 1056.
REQ-005 SHALL have parameters V_VISIBLE 600, V_FRONT 1, V_SYNC 4, V_BACK 23; V_TOTAL = 628.
REQ-006 SHALL have parameter PIPE_LEAD, default 2, clocks by which lineStarting/lineEnding precede the pixel boundary; legal range 1..H_FRONT.
REQ-007 Port clk40  input  1  pixel clock, 40 MHz; the block's only clock.
REQ-008 Port rst  input  1  asynchronous, active-high reset.
REQ-009 Port hPos  output  11  current horizontal count, 0..H_TOTAL-1.
REQ-010 Port vPos  output  10  current line count, 0..V_TOTAL-1.
REQ-011 Port nextVPos  output  10  (vPos+1) mod V_TOTAL.
REQ-012 Port hsync, vsync  output  1 each  positive-polarity sync levels.
REQ-013 Port displayActive  output  1  high while hPos<H_VISIBLE and vPos<V_VISIBLE.
REQ-014 Port hsyncStarting  output  1  one-clock pulse at start of hsync.
REQ-015 Port nextFrameActive  output  1  level: nextVPos<V_VISIBLE.
REQ-016 Port lineStarting, lineEnding  output  1 each  one-clock pulses bracketing pixel reads.

Function
REQ-017 All outputs SHALL be registered; every output SHALL be aligned to the hPos/vPos values presented in the same cycle.
REQ-018 hPos SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0; at that wrap vPos SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-019 nextVPos SHALL equal 0 while vPos=V_TOTAL-1, otherwise vPos+1.
REQ-020 hsync SHALL be high for H_VISIBLE+H_FRONT <= hPos < H_VISIBLE+H_FRONT+H_SYNC (840..967).
REQ-021 vsync SHALL be high for V_VISIBLE+V_FRONT <= vPos < V_VISIBLE+V_FRONT+V_SYNC (601..604), changing only with hPos=0.
REQ-022 hsyncStarting SHALL be high exactly when hPos=H_VISIBLE+H_FRONT (840), on every line including blanking lines.
REQ-023 lineStarting SHALL be high exactly when hPos=H_TOTAL-PIPE_LEAD and nextFrameActive=1 (precedes pixel 0 of each visible line, including line 0 from line 627).
REQ-024 lineEnding SHALL be high exactly when hPos=H_VISIBLE-PIPE_LEAD and vPos<V_VISIBLE.
REQ-025 Each visible line SHALL receive exactly one lineStarting followed by exactly one lineEnding; no pulse SHALL occur on blanking lines except lineStarting on line V_TOTAL-1.
REQ-026 Counter arithmetic SHALL use full port widths with explicit compare-to-terminal wrap; no overflow beyond terminal values is permitted.

Reset
REQ-027 While rst=1: hPos=0, vPos=0, nextVPos=1, hsync=0, vsync=0, displayActive=0, hsyncStarting=0, lineStarting=0, lineEnding=0, nextFrameActive=1.
REQ-028 Reset asserted mid-frame SHALL abort immediately; first clock after release SHALL present hPos=0,vPos=0 with displayActive=1, then count normally.

Configuration
REQ-029 Macro VIDEO_TIMING_FRAME_COUNT_EN defined: SHALL add output frameCount (8 bits), reset 0, incremented when hPos and vPos both wrap to 0, wrapping 255->0.
REQ-030 Macro undefined: port frameCount and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Release reset, run 1056x628 clocks -> hPos/vPos return to 0/0, exactly 628 hsyncStarting pulses, 600 lineStarting, 600 lineEnding.
REQ-032 vPos=599, hPos=1054 -> lineStarting=0, nextFrameActive=0; vPos=627, hPos=1054 -> lineStarting=1, nextVPos=0.
REQ-033 vPos=10: hsync rises at hPos=840, falls at 968; lineEnding at hPos=798; displayActive falls at hPos=800.
REQ-034 Assert rst at vPos=300, hPos=500 for 3 clocks -> all outputs at REQ-027 values within same cycle; restart at 0/0.
REQ-035 vsync high for vPos 601..604 only (4 lines x 1056 clocks).
REQ-036 With VIDEO_TIMING_FRAME_COUNT_EN, run 256 frames -> frameCount steps 0..255 then 0; without macro, bench compiles without frameCount.
